// File: rtl/csa_calc_scheduler.sv
// Round-robin dispatcher/collector sharing one CSA parameter stream across NUM_UNITS calc units.
// A one-word holding register feeds the units; a four-state collector drains their results.
module csa_calc_scheduler #(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned UNIT_IDX_WIDTH = 2,
  parameter int unsigned IN_WIDTH       = 160,
  parameter int unsigned OUT_WIDTH      = 224
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           csa_in_wen,
  input  logic [IN_WIDTH-1:0]            csa_in,
  output logic                           csa_in_full,
  input  logic                           csa_out_ren,
  output logic                           csa_out_ready,
  output logic [OUT_WIDTH-1:0]           csa_out,
  output logic [UNIT_IDX_WIDTH-1:0]      csa_out_unit,
  input  logic [NUM_UNITS-1:0]           unit_in_full,
  output logic [NUM_UNITS-1:0]           unit_in_wen,
  output logic [IN_WIDTH-1:0]            unit_in,
  input  logic [NUM_UNITS-1:0]           unit_out_ready,
  output logic [NUM_UNITS-1:0]           unit_out_ren,
  input  logic [NUM_UNITS*OUT_WIDTH-1:0] unit_out,
  output logic                           busy,
  output logic                           overflow
);

  typedef enum logic [1:0] {StIdle, StRen, StCap, StHold} state_e;

  localparam logic [UNIT_IDX_WIDTH-1:0] LastIdx = UNIT_IDX_WIDTH'(NUM_UNITS - 1);

  function automatic logic [UNIT_IDX_WIDTH-1:0] next_idx(input logic [UNIT_IDX_WIDTH-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + UNIT_IDX_WIDTH'(1);
  endfunction

  // Returns {found, index} of the first candidate at or after start, wrapping.
  function automatic logic [UNIT_IDX_WIDTH:0] rr_pick(input logic [UNIT_IDX_WIDTH-1:0] start,
                                                      input logic [NUM_UNITS-1:0]      cand);
    logic [UNIT_IDX_WIDTH-1:0] idx;
    logic [UNIT_IDX_WIDTH-1:0] pick;
    logic                      found;
    idx   = start;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = next_idx(idx);
    end
    return {found, pick};
  endfunction

  logic                      hold_valid_q;
  logic [IN_WIDTH-1:0]       hold_data_q;
  logic [UNIT_IDX_WIDTH-1:0] in_ptr_q, out_ptr_q;
  logic [UNIT_IDX_WIDTH-1:0] sel_q, sel_d;
  logic [15:0]               outstanding_q, outstanding_d;
  logic                      overflow_q;
  logic [OUT_WIDTH-1:0]      csa_out_q;
  logic [UNIT_IDX_WIDTH-1:0] csa_out_unit_q;
  state_e                    state_q, state_d;

  logic                      disp_found, coll_found;
  logic [UNIT_IDX_WIDTH-1:0] disp_idx, coll_idx;
  logic                      dispatch, accept, collect;
  logic [OUT_WIDTH-1:0]      cap_data;

  // Dispatch side
  always_comb begin
    {disp_found, disp_idx} = rr_pick(in_ptr_q, ~unit_in_full);
    dispatch    = hold_valid_q && disp_found;
    unit_in_wen = '0;
    if (dispatch) unit_in_wen[disp_idx] = 1'b1;
  end

  assign csa_in_full = hold_valid_q && !dispatch;
  assign accept      = csa_in_wen && !csa_in_full;
  assign unit_in     = hold_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      in_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // A write may refill the register in the same cycle it is emptied.
      if (accept) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= csa_in;
      end else if (dispatch) begin
        hold_valid_q <= 1'b0;
      end
      if (dispatch) in_ptr_q <= next_idx(disp_idx);
      if (csa_in_wen && csa_in_full) overflow_q <= 1'b1;
    end
  end

  // Collector side
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    unit_out_ren = '0;
    {coll_found, coll_idx} = rr_pick(out_ptr_q, unit_out_ready);
    unique case (state_q)
      StIdle: begin
        if (coll_found) begin
          sel_d   = coll_idx;
          state_d = StRen;
        end
      end
      StRen: begin
        unit_out_ren[sel_q] = 1'b1;
        state_d             = StCap;
      end
      StCap:  state_d = StHold;
      StHold: if (csa_out_ren) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      if (sel_q == UNIT_IDX_WIDTH'(k)) cap_data = unit_out[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign collect = (state_q == StCap);

  always_comb begin
    outstanding_d = outstanding_q;
    if (dispatch && !collect && outstanding_q != 16'hFFFF) begin
      outstanding_d = outstanding_q + 16'd1;
    end else if (collect && !dispatch && outstanding_q != 16'd0) begin
      outstanding_d = outstanding_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sel_q          <= '0;
      out_ptr_q      <= '0;
      outstanding_q  <= '0;
      csa_out_q      <= '0;
      csa_out_unit_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      outstanding_q <= outstanding_d;
      if (collect) begin
        csa_out_q      <= cap_data;
        csa_out_unit_q <= sel_q;
        out_ptr_q      <= next_idx(sel_q);
      end
    end
  end

  assign csa_out_ready = (state_q == StHold);
  assign csa_out       = csa_out_q;
  assign csa_out_unit  = csa_out_unit_q;
  assign overflow      = overflow_q;
  assign busy          = hold_valid_q || (outstanding_q != 16'd0) || (state_q != StIdle);

endmodule

// File: tb/tb_csa_calc_scheduler.sv
// Bench for csa_calc_scheduler: emulated unit FIFOs plus a cycle-level reference model,
// directed scenarios followed by a randomized run and drain.
module tb_csa_calc_scheduler;

  localparam int NU    = 4;
  localparam int UW    = 2;
  localparam int IW    = 160;
  localparam int OW    = 224;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csa_in_wen = 1'b0;
  logic [IW-1:0] csa_in = '0;
  logic          csa_in_full;
  logic          csa_out_ren = 1'b0;
  logic          csa_out_ready;
  logic [OW-1:0] csa_out;
  logic [UW-1:0] csa_out_unit;
  logic [NU-1:0] unit_in_full = '0;
  logic [NU-1:0] unit_in_wen;
  logic [IW-1:0] unit_in;
  logic [NU-1:0] unit_out_ready = '0;
  logic [NU-1:0] unit_out_ren;
  logic [NU*OW-1:0] unit_out = '0;
  logic          busy;
  logic          overflow;

  csa_calc_scheduler #(
    .NUM_UNITS     (NU),
    .UNIT_IDX_WIDTH(UW),
    .IN_WIDTH      (IW),
    .OUT_WIDTH     (OW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .csa_in_wen    (csa_in_wen),
    .csa_in        (csa_in),
    .csa_in_full   (csa_in_full),
    .csa_out_ren   (csa_out_ren),
    .csa_out_ready (csa_out_ready),
    .csa_out       (csa_out),
    .csa_out_unit  (csa_out_unit),
    .unit_in_full  (unit_in_full),
    .unit_in_wen   (unit_in_wen),
    .unit_in       (unit_in),
    .unit_out_ready(unit_out_ready),
    .unit_out_ren  (unit_out_ren),
    .unit_out      (unit_out),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Unit environment: per-unit FIFO contents plus forcing masks.
  logic [IW-1:0] q [NU][$];
  logic [NU-1:0] force_full = '0;
  logic [NU-1:0] hide_ready = '0;
  logic [NU-1:0] last_wen;

  // Reference model state.
  bit            m_hold;
  logic [IW-1:0] m_data;
  int            m_ptr, m_optr, m_phase, m_sel, m_outst, m_cunit;
  bit            m_ovf;
  logic [OW-1:0] m_cout, m_res;
  logic [IW-1:0] m_uq [NU][$];

  logic [IW-1:0] wb [8];
  logic [IW-1:0] wc0, wc1, wc2;
  bit            found;

  function automatic logic [OW-1:0] res(input logic [IW-1:0] w, input int k);
    return {32'hC0DE_0000 ^ 32'(k), ~w[31:0], w};
  endfunction

  function automatic logic [IW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit qs_empty();
    for (int k = 0; k < NU; k++) if (q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_hold = 0; m_data = '0; m_ptr = 0; m_optr = 0; m_phase = 0; m_sel = 0;
    m_outst = 0; m_ovf = 0; m_cout = '0; m_res = '0; m_cunit = 0;
  endtask

  task automatic upd();
    for (int k = 0; k < NU; k++) begin
      unit_in_full[k]   = force_full[k] | (q[k].size() >= DEPTH);
      unit_out_ready[k] = !hide_ready[k] && (q[k].size() != 0);
    end
  endtask

  // One clock cycle: check outputs against the model, advance model, clock, update units.
  task automatic step();
    int            pick, csel, idx;
    bit            exp_full, inc, dec;
    logic [NU-1:0] exp_wen, exp_ren, wen_s, ren_s;
    logic [IW-1:0] din_s;
    #1;
    pick = -1;
    if (m_hold) begin
      for (int i = 0; i < NU; i++) begin
        idx = (m_ptr + i) % NU;
        if (pick < 0 && !unit_in_full[idx]) pick = idx;
      end
    end
    csel = -1;
    if (m_phase == 0) begin
      for (int i = 0; i < NU; i++) begin
        idx = (m_optr + i) % NU;
        if (csel < 0 && unit_out_ready[idx]) csel = idx;
      end
    end
    exp_wen = '0;
    if (pick >= 0) exp_wen[pick] = 1'b1;
    exp_ren = '0;
    if (m_phase == 1) exp_ren[m_sel] = 1'b1;
    exp_full = m_hold && (pick < 0);
    if (chk_en) begin
      chk("unit_in_wen", unit_in_wen, exp_wen);
      chk("unit_out_ren", unit_out_ren, exp_ren);
      chk("csa_in_full", csa_in_full, exp_full);
      chk("unit_in", unit_in, m_data);
      chk("csa_out_ready", csa_out_ready, (m_phase == 3));
      chk("csa_out", csa_out, m_cout);
      chk("csa_out_unit", csa_out_unit, m_cunit);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (m_hold || m_outst != 0 || m_phase != 0));
    end
    wen_s = unit_in_wen;
    ren_s = unit_out_ren;
    din_s = unit_in;
    inc = (pick >= 0);
    dec = 1'b0;
    if (pick >= 0) begin
      m_uq[pick].push_back(m_data);
      m_hold = 0;
      m_ptr  = (pick + 1) % NU;
    end
    if (csa_in_wen && !exp_full) begin
      m_hold = 1;
      m_data = csa_in;
    end else if (csa_in_wen) begin
      m_ovf = 1;
    end
    case (m_phase)
      0: if (csel >= 0) begin m_sel = csel; m_phase = 1; end
      1: begin
        if (m_uq[m_sel].size() != 0) m_res = res(m_uq[m_sel].pop_front(), m_sel);
        m_phase = 2;
      end
      2: begin
        m_cout = m_res; m_cunit = m_sel; m_optr = (m_sel + 1) % NU; dec = 1; m_phase = 3;
      end
      default: if (csa_out_ren) m_phase = 0;
    endcase
    if (inc && !dec && m_outst < 65535) m_outst++;
    else if (dec && !inc && m_outst > 0) m_outst--;
    if (rst) m_reset();
    last_wen = wen_s;
    @(posedge clk);
    #1;
    for (int k = 0; k < NU; k++) begin
      if (ren_s[k] && q[k].size() != 0) unit_out[k*OW +: OW] = res(q[k].pop_front(), k);
      if (wen_s[k]) q[k].push_back(din_s);
    end
    upd();
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] d);
    csa_in_wen = 1'b1;
    csa_in     = d;
    step();
    csa_in_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; chk_en = 1'b0;
    csa_out_ren = 1'b0;
    step();
    rst = 1'b0; chk_en = 1'b1;
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    step();
    do_reset();

    // Reset, then idle.
    chk("rst_csa_out", csa_out, '0);
    chk("rst_unit_in", unit_in, '0);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("idle_full", csa_in_full, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Back-to-back writes with collection hidden.
    hide_ready = '1; upd();
    for (int i = 0; i < 8; i++) wb[i] = rnd_word();
    for (int i = 0; i < 9; i++) begin
      csa_in_wen = (i < 8);
      csa_in     = (i < 8) ? wb[i] : '0;
      step();
      if (i > 0) chk("wen_seq", last_wen, 4'b0001 << ((i - 1) % 4));
    end
    csa_in_wen = 1'b0;
    for (int k = 0; k < NU; k++) begin
      chk("rx_count", q[k].size(), 2);
      chk("rx_first", q[k][0], wb[k]);
      chk("rx_second", q[k][1], wb[k+4]);
    end
    chk("b2b_busy", busy, 1'b1);

    // Skip full units, hold when all full, overflow, release.
    wc0 = rnd_word(); wc1 = rnd_word(); wc2 = rnd_word();
    force_full = 4'b0011; upd();
    wr(wc0);
    step();
    chk("skip_full", last_wen, 4'b0100);
    force_full = 4'b1111; upd();
    wr(wc1);
    chk("held_full", csa_in_full, 1'b1);
    wr(wc2);
    chk("overflow_set", overflow, 1'b1);
    force_full = 4'b0111; upd();
    step();
    chk("release_u3", last_wen, 4'b1000);
    chk("release_data", q[3][q[3].size()-1], wc1);
    force_full = '0; upd();

    // Collection order and timing from out_ptr=0 with ready=1010.
    do_reset();
    chk("ovf_cleared", overflow, 1'b0);
    hide_ready = 4'b0101; upd();
    step();
    chk("ren_u1", unit_out_ren, 4'b0010);
    step();
    csa_out_ren = 1'b1;
    chk("not_ready_yet", csa_out_ready, 1'b0);
    step();
    csa_out_ren = 1'b0;
    chk("ready_t3", csa_out_ready, 1'b1);
    chk("unit_u1", csa_out_unit, 2'd1);
    chk("data_u1", csa_out, res(wb[1], 1));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_no_ren", unit_out_ren, 4'b0000);
      chk("hold_stable", csa_out, res(wb[1], 1));
    end
    csa_out_ren = 1'b1;
    step();
    csa_out_ren = 1'b0;
    chk("ready_drop", csa_out_ready, 1'b0);
    step();
    chk("ren_u3", unit_out_ren, 4'b1000);
    step();
    step();
    chk("unit_u3", csa_out_unit, 2'd3);
    chk("data_u3", csa_out, res(wb[3], 3));
    csa_out_ren = 1'b1;
    step();
    csa_out_ren = 1'b0;

    // Reset while a word is held and the collector is capturing.
    hide_ready = '0; force_full = '1; upd();
    wr(rnd_word());
    wr(rnd_word());
    csa_out_ren = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (m_phase == 2) found = 1'b1;
      else step();
    end
    chk("reach_cap", found, 1'b1);
    do_reset();
    chk("mid_rst_ready", csa_out_ready, 1'b0);
    chk("mid_rst_full", csa_in_full, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wen", unit_in_wen, '0);
    chk("mid_rst_ren", unit_out_ren, '0);
    chk("mid_rst_out", csa_out, '0);
    chk("mid_rst_unit", csa_out_unit, '0);
    chk("mid_rst_unit_in", unit_in, '0);
    force_full = '0; upd();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      csa_in_wen  = ($urandom % 10) < 6;
      csa_in      = rnd_word();
      csa_out_ren = $urandom % 2;
      force_full  = (($urandom % 8) == 0) ? NU'($urandom) : '0;
      upd();
      step();
    end
    csa_in_wen = 1'b0; force_full = '0; csa_out_ren = 1'b1; upd();
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      if (!m_hold && m_phase == 0 && qs_empty()) found = 1'b1;
      else step();
    end
    chk("drain_done", found, 1'b1);
    step();
    step();
    chk("drain_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
